// File: rtl/net2axis_replay.sv
// rtl/net2axis_replay.sv - AXI4-Stream packet replayer driven from a preloaded hex table
// Table entries are {tlast, tkeep, tdata}; the last entry always closes a packet.
module net2axis_replay #(
  parameter string C_INPUTFILE   = "",
  parameter int    C_TDATA_WIDTH = 32,
  parameter int    C_NUM_WORDS   = 16,
  parameter int    C_IPG         = 0,
  parameter int    C_LOOPS       = 1
) (
  input  logic                         ACLK,
  input  logic                         ARESETN,
  input  logic                         START,
  output logic                         DONE,
  output logic [31:0]                  PKT_COUNT,
  output logic                         M_AXIS_TVALID,
  output logic [C_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic [C_TDATA_WIDTH/8-1:0]   M_AXIS_TKEEP,
  output logic                         M_AXIS_TLAST,
  input  logic                         M_AXIS_TREADY
);

  localparam int KW = C_TDATA_WIDTH / 8;
  localparam int EW = 1 + KW + C_TDATA_WIDTH;
  localparam int PW = (C_NUM_WORDS > 1) ? $clog2(C_NUM_WORDS) : 1;
  localparam int GW = (C_IPG > 1) ? $clog2(C_IPG) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SEND,
    S_GAP,
    S_FINISH
  } state_t;

  logic [EW-1:0] r_mem [C_NUM_WORDS];

  initial begin
    for (int i = 0; i < C_NUM_WORDS; i++) r_mem[i] = '0;
  end

  state_t                r_state;
  logic [PW-1:0]         r_ptr;
  logic [31:0]           r_loop;
  logic [GW-1:0]         r_gap;
  logic                  r_valid;
  logic                  r_tlast;
  logic [C_TDATA_WIDTH-1:0] r_tdata;
  logic [KW-1:0]         r_tkeep;
  logic                  r_done;
  logic [31:0]           r_pkt;

  state_t                w_state_nxt;
  logic [PW-1:0]         w_ptr_nxt;
  logic [31:0]           w_loop_nxt;
  logic [GW-1:0]         w_gap_nxt;
  logic                  w_valid_nxt;
  logic                  w_done_nxt;
  logic                  w_load;
  logic                  w_pkt_inc;
  logic                  w_hs;
  logic                  w_last_idx;
  logic [EW-1:0]         w_entry;

  assign w_hs       = r_valid & M_AXIS_TREADY;
  assign w_last_idx = (r_ptr == PW'(C_NUM_WORDS - 1));
  assign w_entry    = r_mem[w_ptr_nxt];

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_loop_nxt  = r_loop;
    w_gap_nxt   = r_gap;
    w_valid_nxt = r_valid;
    w_done_nxt  = r_done;
    w_load      = 1'b0;
    w_pkt_inc   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (START) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        w_load      = 1'b1;
        w_valid_nxt = 1'b1;
        w_state_nxt = S_SEND;
      end
      S_SEND: begin
        if (w_hs) begin
          w_pkt_inc = r_tlast;
          if (w_last_idx) begin
            w_ptr_nxt  = '0;
            w_loop_nxt = r_loop + 32'd1;
          end else begin
            w_ptr_nxt  = r_ptr + 1'b1;
          end
          // Finishing takes priority over the gap so no idle tail follows the last packet.
          if (w_last_idx && (C_LOOPS != 0) && (w_loop_nxt == 32'(C_LOOPS))) begin
            w_valid_nxt = 1'b0;
            w_done_nxt  = 1'b1;
            w_state_nxt = S_FINISH;
          end else if (r_tlast && (C_IPG > 0)) begin
            w_valid_nxt = 1'b0;
            w_gap_nxt   = '0;
            w_state_nxt = S_GAP;
          end else begin
            w_load = 1'b1;
          end
        end
      end
      S_GAP: begin
        w_gap_nxt = r_gap + 1'b1;
        if (r_gap == GW'(C_IPG - 1)) begin
          w_load      = 1'b1;
          w_valid_nxt = 1'b1;
          w_state_nxt = S_SEND;
        end
      end
      S_FINISH: begin
        w_valid_nxt = 1'b0;
        w_done_nxt  = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_loop  <= '0;
      r_gap   <= '0;
      r_valid <= 1'b0;
      r_tlast <= 1'b0;
      r_tdata <= '0;
      r_tkeep <= '0;
      r_done  <= 1'b0;
      r_pkt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_loop  <= w_loop_nxt;
      r_gap   <= w_gap_nxt;
      r_valid <= w_valid_nxt;
      r_done  <= w_done_nxt;
      if (w_load) begin
        r_tdata <= w_entry[C_TDATA_WIDTH-1:0];
        r_tkeep <= w_entry[C_TDATA_WIDTH+KW-1:C_TDATA_WIDTH];
        r_tlast <= w_entry[EW-1] | (w_ptr_nxt == PW'(C_NUM_WORDS - 1));
      end
      if (w_pkt_inc) r_pkt <= r_pkt + 32'd1;
    end
  end

  assign M_AXIS_TVALID = r_valid;
  assign M_AXIS_TDATA  = r_tdata;
  assign M_AXIS_TKEEP  = r_tkeep;
  assign M_AXIS_TLAST  = r_tlast;
  assign DONE          = r_done;
  assign PKT_COUNT     = r_pkt;

endmodule

// File: tb/tb_net2axis_replay.sv
// tb/tb_net2axis_replay.sv - scoreboard bench for net2axis_replay
// Three instances: IPG=2/LOOPS=2, IPG=0/LOOPS=2, IPG=1/LOOPS=infinite.
module tb_net2axis_replay;

  localparam int W  = 32;
  localparam int KW = 4;
  localparam int N  = 5;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn [NI];
  logic          start  [NI];
  logic          tready [NI];
  logic          tvalid [NI];
  logic          tlast  [NI];
  logic          done   [NI];
  logic [W-1:0]  tdata  [NI];
  logic [KW-1:0] tkeep  [NI];
  logic [31:0]   pkt    [NI];

  function automatic int ipg_of(int k);
    return (k == 0) ? 2 : ((k == 1) ? 0 : 1);
  endfunction

  function automatic int loops_of(int k);
    return (k == 2) ? 0 : 2;
  endfunction

  // Stored table: idx4 deliberately carries tlast=0.
  function automatic logic [36:0] stored(int i);
    logic [31:0] d;
    d = 32'hA0 + 32'(i);
    return {(i == 2), 4'hF, d};
  endfunction

  // Expected output word: the final table entry always ends a packet.
  function automatic logic [36:0] expw(int i);
    logic [36:0] e;
    e = stored(i);
    e[36] = e[36] | (i == N - 1);
    return e;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    net2axis_replay #(
      .C_INPUTFILE   (""),
      .C_TDATA_WIDTH (W),
      .C_NUM_WORDS   (N),
      .C_IPG         ((g == 0) ? 2 : ((g == 1) ? 0 : 1)),
      .C_LOOPS       ((g == 2) ? 0 : 2)
    ) u_dut (
      .ACLK          (clk),
      .ARESETN       (resetn[g]),
      .START         (start[g]),
      .DONE          (done[g]),
      .PKT_COUNT     (pkt[g]),
      .M_AXIS_TVALID (tvalid[g]),
      .M_AXIS_TDATA  (tdata[g]),
      .M_AXIS_TKEEP  (tkeep[g]),
      .M_AXIS_TLAST  (tlast[g]),
      .M_AXIS_TREADY (tready[g])
    );
    initial begin
      #1;
      for (int i = 0; i < N; i++) u_dut.r_mem[i] = stored(i);
    end
  end

  typedef struct {
    int          inst;
    int          id;
    bit          cv;
    logic        ev;
    bit          cd;
    logic        ed;
    bit          cp;
    logic [31:0] ep;
    bit          ce;
  } st_t;

  logic [36:0] exp_q [NI][$];
  st_t         st_q [$];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d: got %h expected %h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Ready pattern driver: 0 always, 1 alternating, 2 random, 3 held low.
  logic [1:0] rmode [NI];
  bit         alt   [NI];
  always @(posedge clk) begin
    #2;
    for (int k = 0; k < NI; k++) begin
      case (rmode[k])
        2'd0: tready[k] = 1'b1;
        2'd1: begin alt[k] = ~alt[k]; tready[k] = alt[k]; end
        2'd2: tready[k] = 1'($urandom_range(0, 1));
        default: tready[k] = 1'b0;
      endcase
    end
  end

  bit          stall [NI];
  bit          gp    [NI];
  int          idle  [NI];
  logic [36:0] held  [NI];

  always @(negedge clk) begin : monitor
    logic [36:0] cur;
    logic [36:0] e;
    st_t         s;
    for (int k = 0; k < NI; k++) begin
      if (resetn[k] !== 1'b1) begin
        exp_q[k].delete();
        stall[k] = 1'b0;
        gp[k]    = 1'b0;
        idle[k]  = 0;
      end else begin
        cur = {tlast[k], tkeep[k], tdata[k]};
        if (stall[k]) begin
          chk("stall_valid", k, 64'(tvalid[k]), 64'd1);
          chk("stall_word", k, 64'(cur), 64'(held[k]));
        end
        if (tvalid[k] && gp[k]) begin
          chk("gap_len", k, 64'(idle[k]), 64'(ipg_of(k)));
          gp[k] = 1'b0;
        end else if (!tvalid[k] && gp[k]) begin
          idle[k]++;
        end
        if (tvalid[k] && tready[k]) begin
          if (exp_q[k].size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL extra_word inst%0d: got %h expected none", k, cur);
          end else begin
            e = exp_q[k].pop_front();
            chk("word", k, 64'(cur), 64'(e));
          end
          if (tlast[k]) begin
            gp[k]   = 1'b1;
            idle[k] = 0;
          end
        end
        stall[k] = tvalid[k] && !tready[k];
        held[k]  = cur;
      end
    end
    if (st_q.size() > 0) begin
      s = st_q.pop_front();
      if (s.cv) chk($sformatf("st%0d_valid", s.id), s.inst, 64'(tvalid[s.inst]), 64'(s.ev));
      if (s.cd) chk($sformatf("st%0d_done", s.id), s.inst, 64'(done[s.inst]), 64'(s.ed));
      if (s.cp) chk($sformatf("st%0d_pkt", s.id), s.inst, 64'(pkt[s.inst]), 64'(s.ep));
      if (s.ce) chk($sformatf("st%0d_drained", s.id), s.inst, 64'(exp_q[s.inst].size()), 64'd0);
    end
  end

  int st_id = 0;
  task automatic push_st(input int k, input bit cv, input logic ev, input bit cd, input logic ed,
                         input bit cp, input logic [31:0] ep, input bit ce);
    st_t s;
    s.inst = k; s.id = st_id; s.cv = cv; s.ev = ev; s.cd = cd; s.ed = ed;
    s.cp = cp; s.ep = ep; s.ce = ce;
    st_id++;
    st_q.push_back(s);
  endtask

  task automatic do_reset(input int k);
    @(posedge clk); #1 resetn[k] = 1'b0;
    @(posedge clk); #1 resetn[k] = 1'b1;
    push_st(k, 1, 1'b0, 1, 1'b0, 1, 32'd0, 0);
  endtask

  task automatic push_words(input int k, input int passes);
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < N; i++) exp_q[k].push_back(expw(i));
  endtask

  task automatic run(input int k, input int passes, input logic [1:0] mode, input bit hold);
    int lasts;
    lasts = 0;
    for (int i = 0; i < N; i++) lasts += int'(expw(i)[36]);
    push_words(k, passes);
    rmode[k] = mode;
    @(posedge clk); #1 start[k] = 1'b1;
    @(posedge clk); #1 if (!hold) start[k] = 1'b0;
    push_st(k, 1, 1'b0, 0, 1'b0, 0, 32'd0, 0);
    @(posedge clk); #1;
    push_st(k, 1, 1'b1, 0, 1'b0, 0, 32'd0, 0);
    for (int c = 0; c < 20000; c++) begin
      if (exp_q[k].size() == 0) break;
      @(posedge clk); #1;
    end
    if (loops_of(k) == 0) begin
      rmode[k] = 2'd3;
      push_st(k, 0, 1'b0, 1, 1'b0, 1, 32'(passes * lasts), 1);
    end else begin
      repeat (4) @(posedge clk);
      #1 push_st(k, 1, 1'b0, 1, 1'b1, 1, 32'(passes * lasts), 1);
      if (hold) begin
        repeat (6) @(posedge clk);
        #1 push_st(k, 1, 1'b0, 1, 1'b1, 1, 32'(passes * lasts), 1);
        start[k] = 1'b0;
      end
    end
    repeat (2) @(posedge clk);
  endtask

  // Stall the second occurrence of A1 (after two packets), then reset mid-packet.
  task automatic reset_mid_stall();
    int seen;
    seen = 0;
    push_words(0, 2);
    rmode[0] = 2'd0;
    @(posedge clk); #1 start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (tvalid[0] && tdata[0] == 32'hA1) seen++;
      if (seen == 2) begin
        rmode[0] = 2'd3;
        break;
      end
    end
    repeat (3) @(posedge clk);
    #1 push_st(0, 1, 1'b1, 1, 1'b0, 1, 32'd2, 0);
    do_reset(0);
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      resetn[k] = 1'b0;
      start[k]  = 1'b0;
      rmode[k]  = 2'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      resetn[k] = 1'b1;
      push_st(k, 1, 1'b0, 1, 1'b0, 1, 32'd0, 0);
    end
    repeat (4) @(posedge clk);

    run(0, 2, 2'd0, 1'b1);
    do_reset(0);
    run(0, 2, 2'd1, 1'b0);
    do_reset(0);
    reset_mid_stall();
    run(0, 2, 2'd2, 1'b0);
    do_reset(0);

    run(1, 2, 2'd0, 1'b0);
    do_reset(1);

    run(2, 100, 2'd2, 1'b0);
    do_reset(2);

    for (int c = 0; c < 100; c++) begin
      if (st_q.size() == 0) break;
      @(posedge clk);
    end
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
